// File: rtl/alu_seq.sv
// Registered N-bit ALU with start/busy/done handshake: single-cycle logic/arith ops
// plus an unsigned shift-add multiply that retires one multiplier bit per clock.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       sel,
    input  logic [WIDTH-1:0] inputA,
    input  logic [WIDTH-1:0] inputB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dataOut,
    output logic [WIDTH-1:0] dataOutHi,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_ADD = 3'b010,
        OP_MUL = 3'b011,
        OP_NOR = 3'b100,
        OP_RSV = 3'b101,
        OP_SUB = 3'b110,
        OP_SLT = 3'b111
    } op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [WIDTH-1:0]   data_hi_q, data_hi_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;
    logic               zero_q, zero_d;
    logic               done_q, done_d;

    // Shared adder: SUB and SLT both form A + ~B + 1.
    logic             is_sub;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;
    logic             add_ovf;
    logic [WIDTH-1:0] alu_res;
    logic             alu_cout;
    logic             alu_ovf;
    logic [WIDTH:0]   step_sum;
    logic [2*WIDTH-1:0] step_prod;

    assign is_sub  = (sel == OP_SUB) || (sel == OP_SLT);
    assign b_eff   = is_sub ? ~inputB : inputB;
    assign sum     = {1'b0, inputA} + {1'b0, b_eff} + (WIDTH+1)'(is_sub);
    assign add_ovf = (inputA[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != inputA[WIDTH-1]);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        alu_res  = '0;
        alu_cout = 1'b0;
        alu_ovf  = 1'b0;
        case (sel)
            OP_AND: alu_res = inputA & inputB;
            OP_OR:  alu_res = inputA | inputB;
            OP_NOR: alu_res = ~(inputA | inputB);
            OP_ADD, OP_SUB: begin
                alu_res  = sum[WIDTH-1:0];
                alu_cout = sum[WIDTH];
                alu_ovf  = add_ovf;
            end
            OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ add_ovf};
            default: alu_res = '0;
        endcase
    end

    // One multiply step: conditionally add the multiplicand into the high half, shift right.
    assign step_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    assign step_prod = {step_sum, prod_q[WIDTH-1:1]};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mcand_d   = mcand_q;
        prod_d    = prod_q;
        data_d    = data_q;
        data_hi_d = data_hi_q;
        cout_d    = cout_q;
        ovf_d     = ovf_q;
        zero_d    = zero_q;
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (sel == OP_MUL) begin
                        state_d = S_BUSY;
                        cnt_d   = '0;
                        mcand_d = inputA;
                        prod_d  = {{WIDTH{1'b0}}, inputB};
                    end else begin
                        data_d    = alu_res;
                        data_hi_d = '0;
                        cout_d    = alu_cout;
                        ovf_d     = alu_ovf;
                        zero_d    = (alu_res == '0);
                        done_d    = 1'b1;
                    end
                end
            end
            S_BUSY: begin
                prod_d = step_prod;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LAST_STEP) begin
                    state_d   = S_IDLE;
                    data_d    = step_prod[WIDTH-1:0];
                    data_hi_d = step_prod[2*WIDTH-1:WIDTH];
                    cout_d    = 1'b0;
                    ovf_d     = 1'b0;
                    zero_d    = (step_prod[WIDTH-1:0] == '0);
                    done_d    = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            mcand_q   <= '0;
            prod_q    <= '0;
            data_q    <= '0;
            data_hi_q <= '0;
            cout_q    <= 1'b0;
            ovf_q     <= 1'b0;
            zero_q    <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mcand_q   <= mcand_d;
            prod_q    <= prod_d;
            data_q    <= data_d;
            data_hi_q <= data_hi_d;
            cout_q    <= cout_d;
            ovf_q     <= ovf_d;
            zero_q    <= zero_d;
            done_q    <= done_d;
        end
    end

    assign busy      = (state_q == S_BUSY);
    assign done      = done_q;
    assign dataOut   = data_q;
    assign dataOutHi = data_hi_q;
    assign cout      = cout_q;
    assign overflow  = ovf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: the driver pushes reference results computed with plain
// integer arithmetic, and a negedge monitor pops and compares on every done pulse.
module tb_alu_seq;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] data;
        logic [W-1:0] hi;
        logic         cout;
        logic         ovf;
        logic         zero;
        int           due;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic [2:0]   sel = 3'b000;
    logic [W-1:0] inputA = '0;
    logic [W-1:0] inputB = '0;
    logic         busy, done, cout, overflow, zero;
    logic [W-1:0] dataOut, dataOutHi;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    exp_t sb[$];

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .sel       (sel),
        .inputA    (inputA),
        .inputB    (inputB),
        .busy      (busy),
        .done      (done),
        .dataOut   (dataOut),
        .dataOutHi (dataOutHi),
        .cout      (cout),
        .overflow  (overflow),
        .zero      (zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint actual, input longint expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Reference model: results straight from integer arithmetic on the operand values.
    function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t   e;
        longint ua, ub, sa, sb_v, r, sr;
        ua = longint'(a);
        ub = longint'(b);
        sa = longint'($signed(a));
        sb_v = longint'($signed(b));
        e.hi = '0;
        e.cout = 1'b0;
        e.ovf = 1'b0;
        e.due = 0;
        r = 0;
        case (op)
            3'b000: r = ua & ub;
            3'b001: r = ua | ub;
            3'b100: r = ~(ua | ub);
            3'b010: begin
                r = ua + ub;
                sr = sa + sb_v;
                e.cout = (r >= (longint'(1) << W));
                e.ovf = (sr > (longint'(1) << (W-1)) - 1) || (sr < -(longint'(1) << (W-1)));
            end
            3'b110: begin
                r = ua - ub;
                sr = sa - sb_v;
                e.cout = (ua >= ub);
                e.ovf = (sr > (longint'(1) << (W-1)) - 1) || (sr < -(longint'(1) << (W-1)));
            end
            3'b111: r = (sa < sb_v) ? 1 : 0;
            3'b011: begin
                r = ua * ub;
                e.hi = r[2*W-1:W];
            end
            default: r = 0;
        endcase
        e.data = r[W-1:0];
        e.zero = (e.data == '0);
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("done_cycle", cyc, e.due);
                check("dataOut", dataOut, e.data);
                check("dataOutHi", dataOutHi, e.hi);
                check("cout", cout, e.cout);
                check("overflow", overflow, e.ovf);
                check("zero", zero, e.zero);
            end
        end
    end

    task automatic check_reset_values();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_dataOut", dataOut, 0);
        check("rst_dataOutHi", dataOutHi, 0);
        check("rst_cout", cout, 0);
        check("rst_overflow", overflow, 0);
        check("rst_zero", zero, 1);
    endtask

    // Called just after a negedge with the DUT idle; returns at the negedge where done is high.
    task automatic do_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit inject);
        exp_t e;
        int   busy_n;
        bit   seen;
        e = model(op, a, b);
        e.due = cyc + 1 + ((op == 3'b011) ? W : 0);
        sb.push_back(e);
        start = 1'b1;
        sel = op;
        inputA = a;
        inputB = b;
        @(negedge clk);
        start = 1'b0;
        if (op == 3'b011) begin
            busy_n = 0;
            seen = 1'b0;
            for (int i = 0; i < W + 4 && !seen; i++) begin
                if (busy) busy_n++;
                if (done) begin
                    seen = 1'b1;
                end else begin
                    if (inject && i == 2) begin
                        start = 1'b1;
                        sel = 3'b010;
                        inputA = 8'h11;
                        inputB = 8'h22;
                    end else begin
                        start = 1'b0;
                    end
                    @(negedge clk);
                end
            end
            start = 1'b0;
            check("mul_done_seen", seen, 1);
            check("mul_busy_cycles", busy_n, W);
        end
    endtask

    initial begin
        logic [2:0] op;

        #2 rst_n = 1'b0;
        #1 check_reset_values();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        do_op(3'b010, 8'hFF, 8'h01, 1'b0);
        do_op(3'b110, 8'h80, 8'h01, 1'b0);
        do_op(3'b111, 8'h80, 8'h01, 1'b0);
        do_op(3'b111, 8'h01, 8'h80, 1'b0);
        do_op(3'b011, 8'hFF, 8'hFF, 1'b1);
        do_op(3'b101, 8'h5A, 8'hA5, 1'b0);
        do_op(3'b100, 8'hF0, 8'h0F, 1'b0);
        do_op(3'b011, 8'h00, 8'h37, 1'b0);

        for (int n = 0; n < 150; n++) begin
            op = 3'($urandom_range(0, 7));
            do_op(op, W'($urandom), W'($urandom), ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 4) == 0) begin
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
        end
        @(negedge clk);
        @(negedge clk);

        // Abort a multiply partway: no done may follow, outputs snap to reset values.
        start = 1'b1;
        sel = 3'b011;
        inputA = 8'h0F;
        inputB = 8'h0F;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("midmul_busy", busy, 1);
        rst_n = 1'b0;
        #1 check_reset_values();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (W + 2) @(negedge clk);
        check("abort_no_done_busy", busy, 0);
        do_op(3'b010, 8'h03, 8'h04, 1'b0);
        check("post_reset_add", dataOut, 8'h07);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, registered N-bit ALU with a start/busy/done handshake. Supports the single-cycle AND/OR/ADD/SUB/SLT set plus NOR and a multi-cycle unsigned shift-add multiply. It is the multi-bit sequential successor to the 1-bit ALU slice and sits between the operand registers and the writeback path of the datapath. All results and flags are registered and hold until the next completed operation.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled on a rising clk edge only when busy=0.
- sel  input  3  operation code, captured with start.
- inputA  input  WIDTH  operand A, captured with start.
- inputB  input  WIDTH  operand B, captured with start.
- busy  output  1  high while a multiply is in progress.
- done  output  1  one-cycle pulse when dataOut/flags are updated.
- dataOut  output  WIDTH  result (low word for MUL).
- dataOutHi  output  WIDTH  high word of MUL product; 0 for all other ops.
- cout  output  1  adder carry-out (ADD/SUB only, else 0).
- overflow  output  1  signed overflow (ADD/SUB only, else 0).
- zero  output  1  dataOut == 0 (all ops; MUL uses the low word only).

## Operation
- Opcodes: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT, 100 NOR, 011 MUL. 101 is reserved: dataOut=0, zero=1, other flags 0, completes as a single-cycle op.
- ADD: A+B with cin=0. SUB: A+~B with cin=1; cout=1 means no borrow.
- overflow = (A[msb]==B'[msb]) && (sum[msb]!=A[msb]), where B' is B for ADD and ~B for SUB.
- SLT: computes A−B internally. dataOut = {0…0, sum[msb]^overflow}, a signed compare. Flags cout and overflow read 0.
- MUL: unsigned WIDTH×WIDTH → 2·WIDTH product via shift-add, one multiplier bit per cycle, LSB first. Result is {dataOutHi, dataOut}.
- FSM has two states:
  - IDLE → BUSY on start with sel=011.
  - All other ops complete directly from IDLE.
  - BUSY → IDLE when the step counter reaches WIDTH.
- start while busy=1 is ignored: no queueing and no effect on the running multiply.
- Reset (asynchronous, any time, including mid-multiply):
  - State returns to IDLE; the step counter and partial product are cleared.
  - Outputs become busy=0, done=0, dataOut=0, dataOutHi=0, cout=0, overflow=0, zero=1.
  - No done pulse is produced for an aborted operation.

## Timing
- Single-cycle ops:
  - start accepted at edge t0; dataOut and flags are updated at t0.
  - done=1 during the cycle following t0 (t0 to t0+1), then returns to 0.
- MUL:
  - Operands captured at t0; busy=1 from t0.
  - One step per edge at t0+1 … t0+WIDTH.
  - At t0+WIDTH the result and flags are loaded, busy=0, and done=1 for one cycle.
  - Latency is WIDTH cycles start-to-done.
- Back-to-back: a new start is accepted in the same cycle done is high, because busy=0 then.
- Outputs change only at a completion edge or on reset; they are stable otherwise.

## Test plan
- Reset values: assert rst_n=0 mid-cycle → busy=0, done=0, dataOut=0, dataOutHi=0, cout=0, overflow=0, zero=1 immediately, without a clock edge.
- ADD wrap (WIDTH=8): A=8'hFF, B=8'h01, sel=010 → dataOut=8'h00, cout=1, overflow=0, zero=1, done pulse 1 cycle after start.
- SUB overflow: A=8'h80, B=8'h01, sel=110 → dataOut=8'h7F, cout=1, overflow=1, zero=0.
- SLT signed: A=8'h80, B=8'h01, sel=111 → dataOut=8'h01. Then A=8'h01, B=8'h80 → dataOut=8'h00.
- MUL with ignored start: A=8'hFF, B=8'hFF, sel=011.
  - Expect busy high for 8 cycles, then done with dataOutHi=8'hFE, dataOut=8'h01.
  - Issue a start with sel=010 at cycle 3 of the multiply; it must be ignored and the product must be unchanged.
- Reset mid-MUL: start MUL 8'h0F×8'h0F, pull rst_n low at cycle 4 → no done pulse, outputs at reset values. After release, ADD 8'h03+8'h04 → dataOut=8'h07 one cycle later.
